// File: rtl/reg_bank_p.sv
// Parameterised register bank: INIT sweep after reset, then one write port and
// two registered read ports with write-first bypass and optional hard-zero register 0.
module reg_bank_p #(
   parameter int                WIDTH      = 32,
   parameter int                DEPTH      = 4,
   parameter int                ZERO_REG   = 0,
   parameter logic [WIDTH-1:0]  INIT_VALUE = '0,
   localparam int               AW         = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             opwrite,
   input  logic [AW-1:0]    reg_write,
   input  logic [WIDTH-1:0] data,
   input  logic             rd_en,
   input  logic [AW-1:0]    src_1,
   input  logic [AW-1:0]    src_2,
   output logic [WIDTH-1:0] data_src_1,
   output logic [WIDTH-1:0] data_src_2,
   output logic             rd_valid,
   output logic             ready,
   output logic             wr_err
);

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [AW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_d1;
   logic [WIDTH-1:0] r_d2;
   logic             r_rd_valid;
   logic             r_wr_err;

   logic             w_zero_wa;
   logic             w_wr_ok;
   logic             w_wr_rej;
   logic             w_rd_ok;
   logic [WIDTH-1:0] w_rd1;
   logic [WIDTH-1:0] w_rd2;

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_INIT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_INIT:  if (r_cnt == AW'(DEPTH - 1)) w_state_nxt = S_READY;
         S_READY: w_state_nxt = S_READY;
         default: w_state_nxt = S_INIT;
      endcase
   end

   assign w_zero_wa = (ZERO_REG != 0) && (reg_write == '0);
   assign w_wr_ok   = opwrite && (r_state == S_READY) && !w_zero_wa;
   assign w_wr_rej  = opwrite && ((r_state == S_INIT) || w_zero_wa);
   assign w_rd_ok   = rd_en && (r_state == S_READY);

   // Hard zero beats the bypass, so a same-edge write to register 0 never leaks out.
   always_comb begin
      w_rd1 = r_mem[src_1];
      w_rd2 = r_mem[src_2];
      if (w_wr_ok && (reg_write == src_1)) w_rd1 = data;
      if (w_wr_ok && (reg_write == src_2)) w_rd2 = data;
      if ((ZERO_REG != 0) && (src_1 == '0)) w_rd1 = '0;
      if ((ZERO_REG != 0) && (src_2 == '0)) w_rd2 = '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt <= '0;
      end else if (r_state == S_INIT) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (r_state == S_INIT) r_mem[r_cnt]     <= INIT_VALUE;
         else if (w_wr_ok)      r_mem[reg_write] <= data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_d1       <= '0;
         r_d2       <= '0;
         r_rd_valid <= 1'b0;
         r_wr_err   <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_ok;
         r_wr_err   <= w_wr_rej;
         if (w_rd_ok) begin
            r_d1 <= w_rd1;
            r_d2 <= w_rd2;
         end
      end
   end

   assign data_src_1 = r_d1;
   assign data_src_2 = r_d2;
   assign rd_valid   = r_rd_valid;
   assign wr_err     = r_wr_err;
   assign ready      = (r_state == S_READY);

endmodule

// File: doc/reg_bank_p.md
REG_BANK_P -- requirements
Module: reg_bank_p

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 4, number of registers; legal values are powers of two from 2 to 256.
REQ-003 Parameter ZERO_REG, default 0; when 1, register 0 always reads zero and ignores writes.
REQ-004 Parameter INIT_VALUE, default 0, WIDTH-bit value loaded into every register by the init sweep.
REQ-005 Derived AW = log2(DEPTH), the address width; it is not a user parameter.
REQ-006 CLK  in  1  single clock; all state updates on the rising edge.
REQ-007 RST  in  1  synchronous reset, active-high.
REQ-008 opwrite  in  1  write request, sampled each rising edge.
REQ-009 reg_write  in  AW  write address.
REQ-010 data  in  WIDTH  write data.
REQ-011 rd_en  in  1  read request for both read ports.
REQ-012 src_1  in  AW  read address for port 1.
REQ-013 src_2  in  AW  read address for port 2.
REQ-014 data_src_1  out  WIDTH  registered read data for port 1.
REQ-015 data_src_2  out  WIDTH  registered read data for port 2.
REQ-016 rd_valid  out  1  one-cycle pulse marking new read data.
REQ-017 ready  out  1  high once the init sweep is complete.
REQ-018 wr_err  out  1  one-cycle pulse marking a rejected write.

Function
REQ-019 The FSM SHALL have two states: INIT (sweep) and READY.
- INIT: a counter starts at 0, writes INIT_VALUE to register[counter] and increments once per cycle.
- INIT goes to READY on the cycle the counter writes register DEPTH-1, which is exactly DEPTH cycles after RST deasserts.
- READY holds until RST.
REQ-020 ready SHALL be 0 in INIT and 1 in READY, asserting on the first cycle after the last sweep write.
REQ-021 In READY, opwrite=1 SHALL write data to register[reg_write] at that rising edge.
- Exception: with ZERO_REG=1 and reg_write=0, the write is discarded.
REQ-022 A write SHALL raise wr_err on the next cycle for exactly one cycle, and leave the register contents unchanged, when:
- opwrite=1 is sampled in INIT; or
- ZERO_REG=1 and reg_write=0.
REQ-023 In READY, rd_en=1 SHALL capture both read ports at that edge and drive data_src_1, data_src_2 and rd_valid=1 on the following cycle (read latency 1).
REQ-024 When opwrite=1 and rd_en=1 are sampled together and the write is accepted, a read port whose address equals reg_write SHALL return the new data (write-first bypass).
REQ-025 With ZERO_REG=1, a read of address 0 SHALL return zero, regardless of any same-cycle write to address 0.
REQ-026 When no read is captured, data_src_1 and data_src_2 SHALL hold their last values and rd_valid SHALL be 0.
REQ-027 rd_en sampled in INIT SHALL be ignored: no rd_valid and no output change.
REQ-028 Back-to-back rd_en SHALL give rd_valid on every cycle, with no bubbles.
REQ-029 src_1 equal to src_2 is legal; both ports SHALL return the same value.
REQ-030 Register contents SHALL be read and written only through this logic; there are no combinational read paths.

Reset
REQ-031 RST=1 sampled at any edge SHALL, on the next cycle:
- enter INIT with the counter at 0;
- set ready=0, rd_valid=0, wr_err=0;
- set data_src_1 and data_src_2 to 0.
REQ-032 An operation in flight when RST is sampled SHALL be discarded:
- a pending read produces no rd_valid;
- a same-edge write is not performed.
REQ-033 While RST stays high the counter SHALL stay at 0, and the sweep SHALL start on the first edge with RST=0.
REQ-034 RST asserted mid-sweep SHALL restart the sweep from register 0.

Verification
REQ-035 Init: pulse RST, DEPTH=4, INIT_VALUE=0 -> ready rises exactly 4 cycles after RST falls; reads of addresses 0 to 3 return 0.
REQ-036 Write/read: write 256 to addr 0 and 128 to addr 1, then rd_en with src_1=0, src_2=1 -> the next cycle shows data_src_1=256, data_src_2=128, rd_valid=1.
REQ-037 Bypass: same edge opwrite=1, reg_write=2, data=0xDEADBEEF, rd_en=1, src_1=2 -> data_src_1=0xDEADBEEF on the next cycle.
REQ-038 Zero register: ZERO_REG=1, write 5 to addr 0 -> wr_err pulses once; a later read of addr 0 returns 0.
REQ-039 Init rejection: opwrite=1 in the second INIT cycle -> wr_err pulses; the target register reads INIT_VALUE after ready.
REQ-040 Reset mid-operation: assert RST on the edge after rd_en -> no rd_valid, outputs 0; test with WIDTH=16, DEPTH=8, where ready returns 8 cycles after RST falls.
